// File: rtl/seg7_pkg.sv
// Shared 7-segment encodings for the display bank (active-low cathodes, bit 6 = a).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg7_dec.sv
// Combinational nibble -> active-low segment decoder.
module hex_to_seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg7(nib);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display driver: double-buffered value/dp, blank window
// at each slot start, optional leading-zero suppression, registered outputs.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_end
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] dp;
    logic [VW-1:0]         val;
  } buf_t;

  logic [TW-1:0] tick_cnt;
  logic [IW-1:0] idx;
  buf_t          shadow, staged, in_buf;
  logic          pending;

  logic          wrap, last_idx, boundary;
  logic [3:0]    cur_nib;
  logic          cur_dp, suppress, lit;
  logic [6:0]    dec_seg;

  assign in_buf   = '{dp: dp_mask, val: value};
  assign wrap     = (tick_cnt == TW'(REFRESH_DIV - 1));
  assign last_idx = (idx == IW'(NUM_DIGITS - 1));
  assign boundary = wrap && last_idx;
  assign frame_end = boundary;

  // Select the current digit and decide whether it is a leading zero:
  // walking from the top digit down, lz_run stays set while every nibble seen is zero.
  always_comb begin
    logic lz_run;
    cur_nib  = '0;
    cur_dp   = 1'b0;
    suppress = 1'b0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (shadow.val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        cur_nib  = shadow.val[4*i +: 4];
        cur_dp   = shadow.dp[i];
        suppress = blank_lz && (i != 0) && lz_run;
      end
    end
  end

  assign lit = enable && (tick_cnt >= TW'(BLANK_CYCLES)) && !suppress;

  hex_to_seg7_dec u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      idx      <= '0;
      shadow   <= '0;
      staged   <= '0;
      pending  <= 1'b0;
      anode_n  <= '1;
      seg      <= SEG_BLANK;
      dp_n     <= 1'b1;
    end else begin
      if (wrap) begin
        tick_cnt <= '0;
        idx      <= last_idx ? '0 : idx + IW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      // Shadow only changes on the frame boundary so a frame never mixes old and new digits.
      if (boundary) begin
        if (load)         shadow <= in_buf;
        else if (pending) shadow <= staged;
        pending <= 1'b0;
      end else if (load) begin
        staged  <= in_buf;
        pending <= 1'b1;
      end

      if (lit) begin
        anode_n <= ~(NUM_DIGITS'(1) << idx);
        seg     <= dec_seg;
        dp_n    <= ~cur_dp;
      end else begin
        anode_n <= '1;
        seg     <= SEG_BLANK;
        dp_n    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a cycle model feeding a scoreboard.
module tb_seven_seg_scanner;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic         clk = 1'b0;
  logic         rst, load, blank_lz, enable;
  logic [15:0]  value;
  logic [3:0]   dp_mask;
  logic [3:0]   anode_n;
  logic [6:0]   seg;
  logic         dp_n, frame_end;

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .enable(enable), .anode_n(anode_n), .seg(seg),
    .dp_n(dp_n), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          vectors = 0;
  int          errs    = 0;
  int          m_tick, m_idx;
  logic [15:0] m_sv, m_stv;
  logic [3:0]  m_sdp, m_stdp;
  logic        m_pend;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model predicts the registered outputs, DUT is compared 1ns after the edge.
  task automatic step();
    exp_t e;
    logic lit, bnd;
    if (rst) begin
      e = '{4'hF, 7'h7F, 1'b1};
      m_tick = 0; m_idx = 0; m_sv = '0; m_stv = '0; m_sdp = '0; m_stdp = '0; m_pend = 1'b0;
    end else begin
      lit = enable && (m_tick >= B) &&
            !(blank_lz && m_idx != 0 && ((m_sv >> (4*m_idx)) == 16'd0));
      if (lit) e = '{~(4'b0001 << m_idx), tbl[m_sv[4*m_idx +: 4]], ~m_sdp[m_idx]};
      else     e = '{4'hF, 7'h7F, 1'b1};
      bnd = (m_tick == R-1) && (m_idx == N-1);
      if (bnd) begin
        if (load)        begin m_sv = value; m_sdp = dp_mask; end
        else if (m_pend) begin m_sv = m_stv; m_sdp = m_stdp; end
        m_pend = 1'b0;
      end else if (load) begin
        m_stv = value; m_stdp = dp_mask; m_pend = 1'b1;
      end
      if (m_tick == R-1) begin
        m_tick = 0;
        m_idx  = (m_idx == N-1) ? 0 : m_idx + 1;
      end else begin
        m_tick = m_tick + 1;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("anode_n", {12'd0, anode_n}, {12'd0, e.an});
    chk("seg", {9'd0, seg}, {9'd0, e.sg});
    chk("dp_n", {15'd0, dp_n}, {15'd0, e.dp});
    chk("frame_end", {15'd0, frame_end}, {15'd0, ((m_tick == R-1) && (m_idx == N-1))});
  endtask

  // Advance until the next step lands on a frame boundary.
  task automatic run_to_boundary();
    int n = 0;
    while (!((m_tick == R-1) && (m_idx == N-1)) && n < 64) begin
      step();
      n++;
    end
    chk("boundary_reached", 16'(n < 64), 16'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [3:0] an_tbl [4];
    logic [6:0] sg_tbl [4];
    int c1, c2;
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_tbl = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};

    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; enable = 1'b0;
    value = '0; dp_mask = '0;
    m_tick = 0; m_idx = 0; m_sv = '0; m_stv = '0; m_sdp = '0; m_stdp = '0; m_pend = 1'b0;
    steps(2);
    chk("reset_anode", {12'd0, anode_n}, 16'h000F);
    chk("reset_seg", {9'd0, seg}, 16'h007F);
    rst = 1'b0;

    // 1: 12AF, fixed per-slot pattern after the first boundary
    enable = 1'b1; value = 16'h12AF; load = 1'b1; step(); load = 1'b0;
    run_to_boundary(); step();
    for (int d = 0; d < 4; d++) begin
      step();
      chk("t1_blank", {12'd0, anode_n}, 16'h000F);
      for (int k = 0; k < 3; k++) begin
        step();
        chk("t1_anode", {12'd0, anode_n}, {12'd0, an_tbl[d]});
        chk("t1_seg", {9'd0, seg}, {9'd0, sg_tbl[d]});
      end
    end

    // 2: two loads within one frame, last wins
    steps(5);
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    steps(3);
    value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    run_to_boundary(); step();
    c1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (seg == 7'b1001111) c1++;
    end
    chk("t2_no_ones", 16'(c1), 16'd0);

    // 3: leading-zero suppression
    blank_lz = 1'b1; value = 16'h0030; load = 1'b1; step(); load = 1'b0;
    run_to_boundary(); step(); steps(16);
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    run_to_boundary(); step();
    c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (anode_n == 4'b1110) c1++;
      else if (anode_n != 4'b1111) c2++;
    end
    chk("t3_d0_lit", 16'(c1), 16'd3);
    chk("t3_others_dark", 16'(c2), 16'd0);

    // 4: decimal point, then enable low
    blank_lz = 1'b0; dp_mask = 4'b0100; value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    run_to_boundary(); step(); steps(16);
    enable = 1'b0;
    c1 = 0; c2 = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_end) c1++;
      if (anode_n != 4'b1111) c2++;
    end
    chk("t4_frame_pulses", 16'(c1), 16'd2);
    chk("t4_dark", 16'(c2), 16'd0);

    // 5: reset mid-slot clears shadow
    enable = 1'b1; steps(5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_anode", {12'd0, anode_n}, 16'h000F);
    chk("t5_seg", {9'd0, seg}, 16'h007F);
    run_to_boundary(); step(); steps(16);

    // 6: load on the boundary cycle goes straight to shadow
    value = 16'hBEEF; dp_mask = 4'b0001;
    run_to_boundary();
    load = 1'b1; step(); load = 1'b0;
    chk("t6_pending", {15'd0, dut.pending}, 16'd0);
    step(); step();
    chk("t6_first_digit", {9'd0, seg}, {9'd0, 7'b0111000});
    chk("t6_dp", {15'd0, dp_n}, 16'd0);
    steps(14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
